// File: rtl/fsm_stim_sequencer_if.sv
// Purpose: bundles the control, table-write, observe and stimulus signals of
//          fsm_stim_sequencer. master = controller/bench side, slave = sequencer.
// Ports:   start/abort/wr_en/wr_addr/wr_data/d/e/f toward the sequencer;
//          a/b/c/busy/done/timeout/step back from it.
interface fsm_stim_sequencer_if #(
  parameter int Depth = 8,
  parameter int CntW  = 8
);
  localparam int PcW = $clog2(Depth);

  logic              start;
  logic              abort;
  logic              wr_en;
  logic [PcW-1:0]    wr_addr;
  logic [CntW+4:0]   wr_data;   // {op[1:0], sel[2:0], count[CntW-1:0]}
  logic              d;
  logic              e;
  logic              f;
  logic              a;
  logic              b;
  logic              c;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [PcW-1:0]    step;

  modport master (
    output start, abort, wr_en, wr_addr, wr_data, d, e, f,
    input  a, b, c, busy, done, timeout, step
  );

  modport slave (
    input  start, abort, wr_en, wr_addr, wr_data, d, e, f,
    output a, b, c, busy, done, timeout, step
  );
endinterface

// File: rtl/fsm_stim_sequencer.sv
// Purpose: programmable stimulus sequencer; runs a small WAIT/DELAY/DRIVE/END
//          table, drives A/B/C pulses and watches D/E/F conditions.
// Latency: start -> FETCH next cycle; each instruction is preceded by a 1-cycle
//          FETCH; DRIVE outputs rise one cycle after the DRIVE state is entered.
// Backpressure: none; WAIT stalls on D/E/F and aborts after TimeoutCycles.
// Ports:   clk, rst (async, active-high); bus = fsm_stim_sequencer_if.slave.
module fsm_stim_sequencer #(
  parameter int Depth         = 8,
  parameter int CntW          = 8,
  parameter int TimeoutCycles = 255
) (
  input logic                 clk,
  input logic                 rst,
  fsm_stim_sequencer_if.slave bus
);

  localparam int              PcW         = $clog2(Depth);
  localparam int              InsW        = CntW + 5;
  localparam logic [1:0]      OpWait      = 2'b00;
  localparam logic [1:0]      OpDelay     = 2'b01;
  localparam logic [1:0]      OpDrive     = 2'b10;
  localparam logic [1:0]      OpEnd       = 2'b11;
  localparam logic [15:0]     TimeoutLast = 16'(TimeoutCycles - 1);
  localparam logic [PcW-1:0]  PcLast      = PcW'(Depth - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DELAY,
    S_DRIVE,
    S_HALT
  } state_t;

  state_t            state_q, state_n;
  logic [PcW-1:0]    pc_q, pc_n;
  logic [CntW-1:0]   cnt_q, cnt_n;
  logic [15:0]       tcnt_q, tcnt_n;
  logic [2:0]        sel_q, sel_n;
  logic [2:0]        drv_q, drv_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              timeout_q, timeout_n;
  logic              wrap_q, wrap_n;   // last entry finished without END
  logic              adv;

  logic [InsW-1:0]   table_q [Depth];
  logic [InsW-1:0]   instr;
  logic [1:0]        op;
  logic [2:0]        isel;
  logic [CntW-1:0]   icnt;
  logic [2:0]        obs;

  assign instr = table_q[pc_q];
  assign op    = instr[CntW+4:CntW+3];
  assign isel  = instr[CntW+2:CntW];
  assign icnt  = instr[CntW-1:0];
  assign obs   = {bus.d, bus.e, bus.f};

  // Writes are only accepted while no program runs, so the table is stable
  // for the whole of a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        table_q[i] <= {OpEnd, 3'b000, {CntW{1'b0}}};
      end
    end else if (bus.wr_en && !busy_q) begin
      table_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      sel_q     <= '0;
      drv_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      pc_q      <= pc_n;
      cnt_q     <= cnt_n;
      tcnt_q    <= tcnt_n;
      sel_q     <= sel_n;
      drv_q     <= drv_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      timeout_q <= timeout_n;
      wrap_q    <= wrap_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    pc_n      = pc_q;
    cnt_n     = cnt_q;
    tcnt_n    = tcnt_q;
    sel_n     = sel_q;
    drv_n     = drv_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    timeout_n = timeout_q;
    wrap_n    = wrap_q;
    adv       = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          state_n   = S_FETCH;
          pc_n      = '0;
          busy_n    = 1'b1;
          timeout_n = 1'b0;
          wrap_n    = 1'b0;
        end
      end
      S_FETCH: begin
        if (wrap_q || op == OpEnd) begin
          state_n = S_HALT;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          wrap_n  = 1'b0;
        end else if (op == OpWait) begin
          state_n = S_WAIT;
          sel_n   = isel;
          tcnt_n  = '0;
        end else if (op == OpDelay) begin
          // A zero delay skips straight to the next FETCH.
          if (icnt == '0) begin
            adv = 1'b1;
          end else begin
            state_n = S_DELAY;
            cnt_n   = icnt;
          end
        end else begin
          // cnt holds the number of high cycles still to drive.
          state_n = S_DRIVE;
          sel_n   = isel;
          cnt_n   = (icnt == '0) ? CntW'(1) : icnt;
        end
      end
      S_WAIT: begin
        if ((obs & sel_q) == sel_q) begin
          adv = 1'b1;
        end else if (tcnt_q == TimeoutLast) begin
          state_n   = S_HALT;
          busy_n    = 1'b0;
          timeout_n = 1'b1;
        end else begin
          tcnt_n = tcnt_q + 16'd1;
        end
      end
      S_DELAY: begin
        if (cnt_q == CntW'(1)) begin
          adv = 1'b1;
        end else begin
          cnt_n = cnt_q - CntW'(1);
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          drv_n = 3'b000;
          adv   = 1'b1;
        end else begin
          drv_n = sel_q;
          cnt_n = cnt_q - CntW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Instruction complete: the last entry holds its PC and lets the next
    // FETCH behave as an END instead of wrapping.
    if (adv) begin
      state_n = S_FETCH;
      if (pc_q == PcLast) begin
        wrap_n = 1'b1;
      end else begin
        pc_n = pc_q + PcW'(1);
      end
    end

    if (bus.abort) begin
      state_n   = S_IDLE;
      pc_n      = '0;
      cnt_n     = '0;
      tcnt_n    = '0;
      drv_n     = 3'b000;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      timeout_n = timeout_q;
      wrap_n    = 1'b0;
    end
  end

  assign {bus.a, bus.b, bus.c} = drv_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.timeout           = timeout_q;
  assign bus.step              = pc_q;

endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// Purpose: self-checking bench for fsm_stim_sequencer: directed vector table,
//          hand-written abort/reset sequences and random programs vs a trace model.
// Ports:   none; instantiates fsm_stim_sequencer_if and the sequencer.
module tb_fsm_stim_sequencer;

  localparam int Depth = 8;
  localparam int CntW  = 8;
  localparam int TO    = 16;

  logic clk;
  logic rst;

  fsm_stim_sequencer_if #(.Depth(Depth), .CntW(CntW)) bus ();

  fsm_stim_sequencer #(
    .Depth(Depth), .CntW(CntW), .TimeoutCycles(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] abc;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [2:0] step;
  } obs_t;

  typedef struct {
    string       name;
    logic [12:0] i0, i1, i2, rest;
    int          d_t;
    logic [2:0]  dval;
    int          end_t, done_n, hi_t, hi_len;
    logic [2:0]  abc;
    logic        to;
    logic [2:0]  step;
  } vec_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [12:0] prog_m [Depth];
  logic [2:0]  obs_m [256];
  obs_t        exp_q [$];
  vec_t        vecs [10];

  function automatic logic [12:0] mk(input logic [1:0] op, input logic [2:0] sel,
                                     input logic [7:0] cnt);
    return {op, sel, cnt};
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.abc     = {bus.a, bus.b, bus.c};
    r.busy    = bus.busy;
    r.done    = bus.done;
    r.timeout = bus.timeout;
    r.step    = bus.step;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes entries Depth-1..1, then entry 0 together with start (edge k).
  // Returns 1 time unit after edge k.
  task automatic load_and_start();
    for (int i = Depth - 1; i >= 1; i--) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'(i);
      bus.wr_data = prog_m[i];
      tick();
    end
    bus.wr_addr = 3'd0;
    bus.wr_data = prog_m[0];
    bus.start   = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic push(input logic [2:0] abc, input logic bz, input logic dn,
                      input logic to, input int pc);
    obs_t r;
    r.abc = abc; r.busy = bz; r.done = dn; r.timeout = to; r.step = 3'(pc);
    exp_q.push_back(r);
  endtask

  // Trace model: expected outputs for every cycle after the start edge,
  // built by emitting the cycles each instruction occupies.
  task automatic run_model();
    int pc, n, cnt, reps;
    logic [1:0] op;
    logic [2:0] sel;
    bit fin, wrap, waiting, to;
    exp_q.delete();
    pc = 0; fin = 0; wrap = 0; to = 0;
    while (!fin) begin
      push(3'b000, 1'b1, 1'b0, 1'b0, pc);                 // fetch cycle
      op  = prog_m[pc][12:11];
      sel = prog_m[pc][10:8];
      cnt = int'(prog_m[pc][7:0]);
      if (wrap || op == 2'd3) begin
        push(3'b000, 1'b0, 1'b1, 1'b0, pc);
        fin = 1;
      end else begin
        if (op == 2'd0) begin
          n = 0; waiting = 1;
          while (waiting) begin
            push(3'b000, 1'b1, 1'b0, 1'b0, pc);
            if ((obs_m[exp_q.size() - 1] & sel) == sel) waiting = 0;
            else begin
              n++;
              if (n == TO) begin
                push(3'b000, 1'b0, 1'b0, 1'b1, pc);
                waiting = 0; fin = 1; to = 1;
              end
            end
          end
        end else if (op == 2'd1) begin
          for (int i = 0; i < cnt; i++) push(3'b000, 1'b1, 1'b0, 1'b0, pc);
        end else begin
          reps = (cnt == 0) ? 1 : cnt;
          push(3'b000, 1'b1, 1'b0, 1'b0, pc);
          for (int i = 0; i < reps; i++) push(sel, 1'b1, 1'b0, 1'b0, pc);
        end
        if (!fin) begin
          if (pc == Depth - 1) wrap = 1;
          else pc++;
        end
      end
    end
    repeat (3) push(3'b000, 1'b0, 1'b0, to, pc);
  endtask

  initial begin
    logic [12:0] e_ins;
    int end_t, dcnt, hi_t, hi_len;
    logic [2:0] abc_or;
    int dens;

    e_ins = mk(2'd3, 3'd0, 8'd0);
    vecs[0] = '{name:"end_only", i0:e_ins, i1:e_ins, i2:e_ins, rest:e_ins, d_t:0, dval:3'b000,
                end_t:1, done_n:1, hi_t:-1, hi_len:0, abc:3'b000, to:1'b0, step:3'd0};
    vecs[1] = '{name:"drive_c3", i0:mk(2'd2, 3'b001, 8'd3), i1:e_ins, i2:e_ins, rest:e_ins,
                d_t:0, dval:3'b000, end_t:6, done_n:1, hi_t:2, hi_len:3, abc:3'b001,
                to:1'b0, step:3'd1};
    vecs[2] = '{name:"wait_d", i0:mk(2'd0, 3'b100, 8'd0), i1:mk(2'd2, 3'b010, 8'd1), i2:e_ins,
                rest:e_ins, d_t:5, dval:3'b100, end_t:10, done_n:1, hi_t:8, hi_len:1,
                abc:3'b010, to:1'b0, step:3'd2};
    vecs[3] = '{name:"wait_timeout", i0:mk(2'd0, 3'b110, 8'd0), i1:e_ins, i2:e_ins, rest:e_ins,
                d_t:0, dval:3'b100, end_t:17, done_n:0, hi_t:-1, hi_len:0, abc:3'b000,
                to:1'b1, step:3'd0};
    vecs[4] = '{name:"delay4", i0:mk(2'd1, 3'b000, 8'd4), i1:e_ins, i2:e_ins, rest:e_ins,
                d_t:0, dval:3'b000, end_t:6, done_n:1, hi_t:-1, hi_len:0, abc:3'b000,
                to:1'b0, step:3'd1};
    vecs[5] = '{name:"delay0", i0:mk(2'd1, 3'b000, 8'd0), i1:e_ins, i2:e_ins, rest:e_ins,
                d_t:0, dval:3'b000, end_t:2, done_n:1, hi_t:-1, hi_len:0, abc:3'b000,
                to:1'b0, step:3'd1};
    vecs[6] = '{name:"drive_cnt0", i0:mk(2'd2, 3'b111, 8'd0), i1:e_ins, i2:e_ins, rest:e_ins,
                d_t:0, dval:3'b000, end_t:4, done_n:1, hi_t:2, hi_len:1, abc:3'b111,
                to:1'b0, step:3'd1};
    vecs[7] = '{name:"wait_sel0", i0:mk(2'd0, 3'b000, 8'd0), i1:e_ins, i2:e_ins, rest:e_ins,
                d_t:0, dval:3'b000, end_t:3, done_n:1, hi_t:-1, hi_len:0, abc:3'b000,
                to:1'b0, step:3'd1};
    vecs[8] = '{name:"pc_wrap", i0:mk(2'd1, 3'b000, 8'd1), i1:mk(2'd1, 3'b000, 8'd1),
                i2:mk(2'd1, 3'b000, 8'd1), rest:mk(2'd1, 3'b000, 8'd1), d_t:0, dval:3'b000,
                end_t:17, done_n:1, hi_t:-1, hi_len:0, abc:3'b000, to:1'b0, step:3'd7};
    vecs[9] = '{name:"two_drives", i0:mk(2'd2, 3'b010, 8'd2), i1:mk(2'd2, 3'b001, 8'd1),
                i2:e_ins, rest:e_ins, d_t:0, dval:3'b000, end_t:8, done_n:1, hi_t:2,
                hi_len:3, abc:3'b011, to:1'b0, step:3'd2};

    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.wr_en = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0;
    bus.d = 1'b0; bus.e = 1'b0; bus.f = 1'b0;
    #12;
    chk("reset_outputs", 32'(sample()), 32'd0);
    #1 rst = 1'b0;
    tick();
    chk("idle_after_reset", 32'(sample()), 32'd0);

    // Directed vector table.
    for (int v = 0; v < 10; v++) begin
      prog_m[0] = vecs[v].i0;
      prog_m[1] = vecs[v].i1;
      prog_m[2] = vecs[v].i2;
      for (int i = 3; i < Depth; i++) prog_m[i] = vecs[v].rest;
      load_and_start();
      end_t = -1; dcnt = 0; hi_t = -1; hi_len = 0; abc_or = 3'b000;
      for (int t = 0; t < 40; t++) begin
        if (bus.done) dcnt++;
        if (end_t < 0 && !bus.busy) end_t = t;
        if ({bus.a, bus.b, bus.c} != 3'b000) begin
          if (hi_t < 0) hi_t = t;
          hi_len++;
          abc_or = abc_or | {bus.a, bus.b, bus.c};
        end
        {bus.d, bus.e, bus.f} = (t >= vecs[v].d_t) ? vecs[v].dval : 3'b000;
        tick();
      end
      {bus.d, bus.e, bus.f} = 3'b000;
      chk({vecs[v].name, ".end_t"},   32'(end_t),         32'(vecs[v].end_t));
      chk({vecs[v].name, ".done_n"},  32'(dcnt),          32'(vecs[v].done_n));
      chk({vecs[v].name, ".hi_t"},    32'(hi_t),          32'(vecs[v].hi_t));
      chk({vecs[v].name, ".hi_len"},  32'(hi_len),        32'(vecs[v].hi_len));
      chk({vecs[v].name, ".abc"},     32'(abc_or),        32'(vecs[v].abc));
      chk({vecs[v].name, ".timeout"}, 32'(bus.timeout),   32'(vecs[v].to));
      chk({vecs[v].name, ".step"},    32'(bus.step),      32'(vecs[v].step));
    end

    // Abort from HALT keeps the sticky timeout; a fresh start clears it.
    prog_m[0] = mk(2'd0, 3'b110, 8'd0);
    for (int i = 1; i < Depth; i++) prog_m[i] = e_ins;
    load_and_start();
    repeat (17) tick();
    chk("to_seq.timeout", 32'(bus.timeout), 32'd1);
    chk("to_seq.busy",    32'(bus.busy),    32'd0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_keeps_timeout", 32'(sample()), 32'({3'b000, 1'b0, 1'b0, 1'b1, 3'd0}));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_clears_timeout", 32'(sample()), 32'({3'b000, 1'b1, 1'b0, 1'b0, 3'd0}));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;

    // Abort mid-DRIVE with a simultaneous start and write to entry 0.
    prog_m[0] = mk(2'd2, 3'b111, 8'd10);
    load_and_start();
    repeat (5) tick();
    chk("abort_seq.pre_abc", 32'({bus.a, bus.b, bus.c}), 32'd7);
    bus.abort = 1'b1; bus.start = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = e_ins;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
    chk("abort_seq.after", 32'(sample()), 32'd0);
    tick();
    chk("abort_seq.idle", 32'(sample()), 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("abort_seq.entry_intact", 32'({bus.a, bus.b, bus.c}), 32'd7);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;

    // Asynchronous reset between clock edges while driving.
    load_and_start();
    repeat (4) tick();
    chk("areset.pre_abc", 32'({bus.a, bus.b, bus.c}), 32'd7);
    #2 rst = 1'b1;
    #1;
    chk("areset.immediate", 32'(sample()), 32'd0);
    #3 rst = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("areset.busy", 32'(bus.busy), 32'd1);
    tick();
    chk("areset.done_end", 32'(sample()), 32'({3'b000, 1'b0, 1'b1, 1'b0, 3'd0}));

    // Random programs against the trace model, with ignored start/writes
    // sprinkled in while busy.
    for (int it = 0; it < 40; it++) begin
      dens = $urandom_range(1, 3);
      for (int i = 0; i < Depth; i++) begin
        int r;
        r = $urandom_range(0, 9);
        prog_m[i] = mk((r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3,
                       3'($urandom), 8'($urandom_range(0, 5)));
      end
      for (int t = 0; t < 256; t++) begin
        obs_m[t] = {($urandom_range(0, 3) < dens), ($urandom_range(0, 3) < dens),
                    ($urandom_range(0, 3) < dens)};
      end
      run_model();
      load_and_start();
      for (int t = 0; t < exp_q.size(); t++) begin
        chk($sformatf("rand%0d.cycle%0d", it, t), 32'(sample()), 32'(exp_q[t]));
        {bus.d, bus.e, bus.f} = obs_m[t];
        bus.start   = exp_q[t].busy && ($urandom_range(0, 7) == 0);
        bus.wr_en   = exp_q[t].busy && ($urandom_range(0, 7) == 0);
        bus.wr_addr = 3'($urandom);
        bus.wr_data = 13'($urandom);
        tick();
      end
      bus.start = 1'b0; bus.wr_en = 1'b0;
      {bus.d, bus.e, bus.f} = 3'b000;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fsm_stim_sequencer.md
Name: fsm_stim_sequencer

Overview:
- Hardware stimulus driver for the A/B/C-input / D/E/F-output state-machine family; the initiator end of that interface.
- Runs a small programmable instruction table. Drives A/B/C pulses, waits on observed D/E/F conditions, inserts delays, and flags completion or timeout.
- Replaces hand-written initial-block stimulus, so directed sequences can run in silicon or in the bench.

Parameters:
- Depth, 8, number of instruction-table entries (power of 2, PC width = log2(Depth)).
- CntW, 8, width of the instruction count field.
- TimeoutCycles, 255, maximum cycles a WAIT may stall before abort (1..2^16-1).

Ports:
- i$Clock  in  1  system clock, rising edge.
- i$Reset  in  1  reset, asynchronous, active-high.
- i$Start  in  1  start program at entry 0; honoured in IDLE or HALT only.
- i$Abort  in  1  synchronous abort to IDLE; wins over i$Start.
- i$WrEn  in  1  table write strobe; ignored while o$Busy=1.
- i$WrAddr  in  log2(Depth)  table write address.
- i$WrData  in  5+CntW  instruction {op[1:0], sel[2:0], count[CntW-1:0]}.
- i$D, i$E, i$F  in  1 each  observed DUT outputs, synchronous to i$Clock; sel bit2=D, bit1=E, bit0=F.
- o$A, o$B, o$C  out  1 each  registered stimulus; sel bit2=A, bit1=B, bit0=C.
- o$Busy  out  1  program executing.
- o$Done  out  1  one-cycle pulse on normal completion.
- o$Timeout  out  1  sticky; WAIT expired; cleared by next Start or reset.
- o$Step  out  log2(Depth)  current PC.

Behaviour:
- Reset (async):
  - All outputs 0.
  - State IDLE, PC 0, counters 0.
  - Every table entry loaded with op=END (11), sel=0, count=0.
- Opcodes:
  - 00 WAIT: stall until ({i$D,i$E,i$F} & sel) == sel. sel=000 is satisfied immediately.
  - 01 DELAY: idle for count cycles; count=0 means zero extra cycles.
  - 10 DRIVE: {o$A,o$B,o$C}=sel for exactly max(count,1) cycles, then 000.
  - 11 END: finish.
- States:
  - IDLE -> FETCH on Start (PC=0, o$Busy=1, o$Timeout cleared).
  - FETCH (1 cycle) -> WAIT / DELAY / DRIVE / HALT by op.
  - WAIT / DELAY / DRIVE -> FETCH with PC+1 when complete.
  - WAIT -> HALT with o$Timeout=1 once TimeoutCycles cycles elapse unsatisfied. Condition sampled true in cycle TimeoutCycles still counts as satisfied.
  - HALT: o$Busy=0. Start -> FETCH (restart); otherwise remain.
- Latency:
  - Start sampled at edge k: o$Busy=1 after edge k, FETCH during cycle k+1.
  - First DRIVE outputs high after edge k+2.
  - END fetched: o$Done=1 for the cycle after the FETCH edge, o$Busy falls on the same edge.
- Instruction hand-off:
  - WAIT satisfied at edge j: next instruction effect after edge j+2.
  - A FETCH cycle always separates instructions, so outputs are 000 for at least one cycle between consecutive DRIVEs.
- PC wrap: completing entry Depth-1 without END behaves as END (o$Done pulse, HALT). PC never wraps to 0 mid-run.
- Abort: next edge gives outputs 000, o$Busy=0, IDLE, PC=0. o$Done is not pulsed and o$Timeout is unchanged.
- Start while Busy is ignored.
- Write while Busy is dropped silently.
- Write and Start in the same cycle from IDLE: write lands first, the program sees the new entry.
- Counters are saturating-free. The count field is compared against an internal CntW counter and the timeout against a 16-bit counter; no overflow is possible within limits.

Test Plan:
- Reset then Start, table untouched: entry 0 is END, so o$Done=1 exactly at cycle k+2 and o$A/B/C stay 000; o$Step=0.
- Table {DRIVE sel=001 cnt=3, END}, Start at edge k: o$C=1 after edges k+2..k+4, 0 after k+5; o$Done pulse one cycle after k+6 edge; o$Step 0->1.
- Table {WAIT sel=100, DRIVE sel=010 cnt=1, END}, raise i$D 5 cycles after Start: o$B high for exactly one cycle, starting 2 edges after i$D first sampled high; o$Timeout=0.
- TimeoutCycles=16, table {WAIT sel=110, END}, i$D=1 with i$E held 0: o$Timeout=1 and o$Busy=0 after 16 WAIT cycles; o$Done never pulses. A second Start clears o$Timeout.
- Table {DRIVE 111 cnt=10, END}; assert i$Abort in the 4th drive cycle together with i$Start and a write to entry 0: outputs 000 next edge, IDLE, write discarded (readback via rerun shows DRIVE 111 intact).
- Assert i$Reset asynchronously mid-DRIVE, between clock edges: outputs drop immediately. After release, Start yields an immediate o$Done because the table has been reset to END.
